adder_share_arbiter: RTL
========================

Name: adder_share_arbiter

Overview:
- Shares one pipelined 8-bit adder (fixed latency, no backpressure, operands sampled every clock) between NREQ requesters.
- Round-robin arbitration selects at most one operand pair per cycle and drives it onto the adder input bus.
- A valid/ID shift pipe tracks each issued operation through the adder latency and returns the result, registered, to the requester that issued it.
- Sits between client blocks and the adder instance; the adder itself stays outside this module.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDER_LAT, 2, clock edges from operand sample to adder_sum/adder_cout stable (>=1).
- IDW, 2, width of the requester index; must equal clog2(NREQ).

Ports:
- enable  input  1  clock, rising edge active.
- rst  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operation request.
- req_a  input  NREQ*8  operand A; requester i uses bits [8i+7:8i].
- req_b  input  NREQ*8  operand B; same packing as req_a.
- req_cin  input  NREQ  carry-in per requester.
- req_ready  output  NREQ  one-hot grant; a handshake completes when req_valid[i] and req_ready[i] are both high.
- adder_a  output  8  operand A to the adder.
- adder_b  output  8  operand B to the adder.
- adder_cin  output  1  carry-in to the adder.
- adder_sum  input  8  adder result.
- adder_cout  input  1  adder carry-out.
- resp_valid  output  NREQ  one-hot, one-cycle result strobe.
- resp_sum  output  8  returned sum.
- resp_cout  output  1  returned carry.
- busy  output  1  high while any operation is in flight.

Behaviour:
- Clock port is enable; reset is rst, asynchronous and active-low.
- Reset values: rr_ptr=0, tag pipe cleared (all valid bits 0), resp_valid=0, resp_sum=0, resp_cout=0, busy=0.
- While rst is low, req_ready=0 and adder_a/adder_b/adder_cin=0.
- Arbitration is combinational within the cycle:
  - Search starts at rr_ptr and wraps through indices rr_ptr, rr_ptr+1, ... NREQ-1, 0, ...
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other req_ready bits are 0.
  - req_ready never asserts for a requester whose req_valid is low.
- Adder drive:
  - On a grant: adder_a/adder_b/adder_cin = operands of the granted requester.
  - No grant: all three are driven 0.
- rr_ptr update at the clock edge:
  - Grant to i: rr_ptr <= (i+1) mod NREQ.
  - No grant: rr_ptr unchanged.
- Tag pipe:
  - ADDER_LAT stages of {valid, IDW-bit id}; it shifts every edge.
  - Stage 0 loads {1, i} on a handshake, {0, x} otherwise.
- Latency: a handshake in cycle t yields resp_valid[i]=1 in cycle t+ADDER_LAT+1, for exactly one cycle.
  - resp_sum/resp_cout are registered from adder_sum/adder_cout at the end of cycle t+ADDER_LAT.
- Throughput: one issue per cycle sustained. Back-to-back results return in issue order with no gaps.
- Response hold: resp_sum/resp_cout hold their last value when resp_valid=0.
- Response backpressure: none. Requesters must accept a result in its strobe cycle.
- Arithmetic: {resp_cout, resp_sum} = req_a + req_b + req_cin, 9-bit. The adder computes this; the controller only transports it unmodified.
- busy = OR of all tag-pipe valid bits, plus the registered response-valid stage.
- A requester may keep req_valid high across cycles. Each handshake is a separate operation.
- Simultaneous requests: served in strict rotation, so every active requester is granted within NREQ cycles (no starvation).
- Reset mid-operation: in-flight tags are discarded. No resp_valid is produced for them after reset releases.

Optional Feature:
- Macro ADD_ARB_PERF_CNT_EN.
- Defined:
  - Adds input perf_clr (1 bit) and output perf_grant_cnt (NREQ*16), a per-requester 16-bit grant counter.
  - A counter increments on each handshake and saturates at 16'hFFFF.
  - perf_clr=1 zeroes all counters at the next edge; when it coincides with a grant, clear wins.
  - Counters reset to 0 on rst low.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
- Reset with req_valid=4'b1111 held -> req_ready=0, resp_valid=0, busy=0. First cycle after release grants requester 0.
- Single request, req 2: a=8'hF0, b=8'h0F, cin=1, ADDER_LAT=2, issued in cycle t -> resp_valid=4'b0100 in cycle t+3, resp_sum=8'h00, resp_cout=1.
- All four requesters valid continuously -> grants 0,1,2,3,0,... one per cycle. Results return in the same order, each in its strobe cycle.
- req_valid=4'b1010 with rr_ptr=2 -> grant 3, then 1, then 3. Requesters 0 and 2 are never granted.
- Three operations issued, then rst pulsed low for one cycle mid-flight -> no resp_valid after release, busy=0, rr_ptr=0.
- With ADD_ARB_PERF_CNT_EN: 5 grants to req 1, then perf_clr asserted in the same cycle as a 6th grant -> counter reads 5 before that edge, 0 after it.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: shares one external pipelined 8-bit adder between NREQ
// requesters. A round-robin arbiter issues at most one operand pair per cycle.
// A valid/id tag pipe follows each issued operation through the adder latency.
// The registered result is then returned to the requester that issued it.
//
// Optional build macro: ADD_ARB_PERF_CNT_EN adds perf_clr and perf_grant_cnt.
// These implement saturating 16-bit grant counters, one per requester.
module adder_share_arbiter #(
    parameter int NREQ      = 4,
    parameter int ADDER_LAT = 2,
    parameter int IDW       = 2
) (
    input  logic              enable,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        adder_a,
    output logic [7:0]        adder_b,
    output logic              adder_cin,
    input  logic [7:0]        adder_sum,
    input  logic              adder_cout,
`ifdef ADD_ARB_PERF_CNT_EN
    input  logic               perf_clr,
    output logic [NREQ*16-1:0] perf_grant_cnt,
`endif
    output logic [NREQ-1:0]   resp_valid,
    output logic [7:0]        resp_sum,
    output logic              resp_cout,
    output logic              busy
);

    logic [IDW-1:0]       r_rr_ptr;
    logic [ADDER_LAT-1:0] r_tag_vld;
    logic [IDW-1:0]       r_tag_id [ADDER_LAT];
    logic [NREQ-1:0]      r_resp_valid;
    logic [7:0]           r_resp_sum;
    logic                 r_resp_cout;

    logic                 w_grant_found;
    logic [IDW-1:0]       w_grant_idx;
    logic [IDW-1:0]       w_cand;
    logic [NREQ-1:0]      w_grant;

    // Round-robin search from r_rr_ptr, wrapping; suppressed while reset is held.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = IDW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_grant_found && req_valid[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
        if (!rst) begin
            w_grant_found = 1'b0;
        end
    end

    // One-hot grant and operand mux onto the shared adder bus (zeros when idle).
    always_comb begin
        w_grant   = '0;
        adder_a   = '0;
        adder_b   = '0;
        adder_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_found && (w_grant_idx == IDW'(i))) begin
                w_grant[i] = 1'b1;
                adder_a    = req_a[i*8 +: 8];
                adder_b    = req_b[i*8 +: 8];
                adder_cin  = req_cin[i];
            end
        end
    end

    assign req_ready = w_grant;

    // Round-robin pointer advances past the requester just served.
    always_ff @(posedge enable or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            r_rr_ptr <= '0;
        end else if (w_grant_found) begin
            r_rr_ptr <= (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    // Tag pipe: one stage per adder latency edge, loaded with {1, id} on a handshake.
    always_ff @(posedge enable or negedge rst) begin
        if (!rst) begin
            r_tag_vld <= '0;
            // NOTE: the id fields are only meaningful under their valid bit, but
            // they are cleared too so the pipe never carries X after reset.
            for (int s = 0; s < ADDER_LAT; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            for (int s = ADDER_LAT - 1; s > 0; s--) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
            r_tag_vld[0] <= w_grant_found;
            r_tag_id[0]  <= w_grant_idx;
        end
    end

    // Capture the adder result when the matching tag leaves the pipe; hold it otherwise.
    always_ff @(posedge enable or negedge rst) begin
        if (!rst) begin
            r_resp_valid <= '0;
            r_resp_sum   <= '0;
            r_resp_cout  <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                r_resp_valid[i] <= r_tag_vld[ADDER_LAT-1] &&
                                   (r_tag_id[ADDER_LAT-1] == IDW'(i));
            end
            if (r_tag_vld[ADDER_LAT-1]) begin
                r_resp_sum  <= adder_sum;
                r_resp_cout <= adder_cout;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_sum   = r_resp_sum;
    assign resp_cout  = r_resp_cout;
    assign busy       = (|r_tag_vld) | (|r_resp_valid);

`ifdef ADD_ARB_PERF_CNT_EN
    logic [15:0] r_perf_cnt [NREQ];

    // Per-requester saturating grant counters; a clear beats a coincident grant.
    always_ff @(posedge enable or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                r_perf_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (perf_clr) begin
                    r_perf_cnt[i] <= '0;
                end else if (w_grant[i] && (r_perf_cnt[i] != 16'hFFFF)) begin
                    r_perf_cnt[i] <= r_perf_cnt[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_perf_out
        assign perf_grant_cnt[g*16 +: 16] = r_perf_cnt[g];
    end
`endif

endmodule
